mips_multicycle: RTL

Multicycle MIPS core: a parametrised successor to the single-cycle `mips` top. One unified memory port with a req/ready handshake serves both instructions and data, so the core tolerates wait-states. A Moore FSM sequences FETCH, DECODE, EXECUTE, MEM and WRITEBACK, with one shared ALU. It keeps the `pc_run_en_i`, `pc_clr_i` and register debug-read controls of the single-cycle top, so board-level debug logic carries over unchanged.

---
 rtl/mips_multicycle_if.sv | 12 +
 rtl/mips_multicycle.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_if.sv
// Unified instruction/data memory port with a req/ready handshake.
interface mips_multicycle_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core (add/sub/and/or/slt, lw/sw/addi/beq/j) with one shared
// ALU and a single wait-state tolerant memory port.
//
// state   | meaning
// FETCH   | request IR at PC; on completion IR<=rdata, PC<=PC+4
// DECODE  | A/B <= rs/rt, ALUOut <= branch target, dispatch on opcode
// MEMADR  | ALUOut <= A + sext(imm)
// MEMRD   | load request; MDR <= rdata on completion
// MEMWB   | rt <= MDR
// MEMWR   | store request
// EXEC    | ALUOut <= A op B
// ALUWB   | rd <= ALUOut
// BRANCH  | PC <= ALUOut when A == B
// ADDIEX  | ALUOut <= A + sext(imm)
// ADDIWB  | rt <= ALUOut
// JUMP    | PC <= {PC[31:28], target, 00}
// HALT    | unsupported instruction; only reset or pc_clr_i leaves
module mips_multicycle #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          ADDR_W          = 32,
  parameter bit          HALT_ON_UNKNOWN = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     pc_run_en_i,
  input  logic                     pc_clr_i,
  mips_multicycle_if.master        mem_bus,
  output logic [31:0]              pc_o,
  output logic [3:0]               state_o,
  output logic                     instr_done_o,
  output logic                     halted_o,
  input  logic [4:0]               ra_debug_i,
  output logic [31:0]              ra_debug_data_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
                         OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                         FN_OR = 6'h25, FN_SLT = 6'h2A;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_pc, r_ir, r_a, r_b, r_alu_out, r_mdr;
  logic [31:0]       r_regs [32];
  logic              r_req, r_we, r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic [5:0]        w_op, w_funct;
  logic [4:0]        w_rs, w_rt, w_rd;
  logic [31:0]       w_imm_sext;
  logic              w_rtype_ok, w_fire;
  logic [31:0]       w_alu_a, w_alu_b, w_alu_y;
  alu_t              w_alu_op;
  logic [31:0]       w_pc_nxt;
  logic              w_req_nxt;
  logic              w_rf_we;
  logic [4:0]        w_rf_waddr;
  logic [31:0]       w_rf_wdata;

  assign w_op       = r_ir[31:26];
  assign w_rs       = r_ir[25:21];
  assign w_rt       = r_ir[20:16];
  assign w_rd       = r_ir[15:11];
  assign w_funct    = r_ir[5:0];
  assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_rtype_ok = (w_funct == FN_ADD) || (w_funct == FN_SUB) || (w_funct == FN_AND) ||
                      (w_funct == FN_OR)  || (w_funct == FN_SLT);
  assign w_fire     = r_req & mem_bus.ready;

  always_comb begin
    w_alu_a  = r_a;
    w_alu_b  = w_imm_sext;
    w_alu_op = ALU_ADD;
    if (r_state == S_DECODE) begin
      w_alu_a = r_pc;
      w_alu_b = {w_imm_sext[29:0], 2'b00};
    end else if (r_state == S_EXEC) begin
      w_alu_b = r_b;
      case (w_funct)
        FN_SUB:  w_alu_op = ALU_SUB;
        FN_AND:  w_alu_op = ALU_AND;
        FN_OR:   w_alu_op = ALU_OR;
        FN_SLT:  w_alu_op = ALU_SLT;
        default: w_alu_op = ALU_ADD;
      endcase
    end
    case (w_alu_op)
      ALU_SUB: w_alu_y = w_alu_a - w_alu_b;
      ALU_AND: w_alu_y = w_alu_a & w_alu_b;
      ALU_OR:  w_alu_y = w_alu_a | w_alu_b;
      ALU_SLT: w_alu_y = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
      default: w_alu_y = w_alu_a + w_alu_b;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:  if (w_fire) w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_LW, OP_SW: w_state_nxt = S_MEMADR;
          OP_RTYPE:     w_state_nxt = w_rtype_ok ? S_EXEC
                                    : (HALT_ON_UNKNOWN ? S_HALT : S_FETCH);
          OP_BEQ:       w_state_nxt = S_BRANCH;
          OP_ADDI:      w_state_nxt = S_ADDIEX;
          OP_J:         w_state_nxt = S_JUMP;
          default:      w_state_nxt = HALT_ON_UNKNOWN ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: w_state_nxt = (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (w_fire) w_state_nxt = S_MEMWB;
      S_MEMWR:  if (w_fire) w_state_nxt = S_FETCH;
      S_EXEC:   w_state_nxt = S_ALUWB;
      S_ADDIEX: w_state_nxt = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: w_state_nxt = S_FETCH;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_FETCH;
    endcase
    if (pc_clr_i) w_state_nxt = S_FETCH;
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (pc_clr_i)                            w_pc_nxt = RESET_PC;
    else if (r_state == S_FETCH && w_fire)   w_pc_nxt = r_pc + 32'd4;
    else if (r_state == S_BRANCH && r_a == r_b) w_pc_nxt = r_alu_out;
    else if (r_state == S_JUMP)              w_pc_nxt = {r_pc[31:28], r_ir[25:0], 2'b00};
  end

  // A fetch already on the bus stays up until accepted, independent of run_en.
  always_comb begin
    w_req_nxt = 1'b0;
    if (!pc_clr_i) begin
      case (w_state_nxt)
        S_FETCH:          w_req_nxt = (r_state == S_FETCH && r_req) ? 1'b1 : pc_run_en_i;
        S_MEMRD, S_MEMWR: w_req_nxt = 1'b1;
        default:          w_req_nxt = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = w_rt;
    w_rf_wdata = r_alu_out;
    case (r_state)
      S_ALUWB:  begin w_rf_we = 1'b1; w_rf_waddr = w_rd; end
      S_ADDIWB: w_rf_we = 1'b1;
      S_MEMWB:  begin w_rf_we = 1'b1; w_rf_wdata = r_mdr; end
      default:  w_rf_we = 1'b0;
    endcase
    if (pc_clr_i) w_rf_we = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_req   <= w_req_nxt;
      r_we    <= !pc_clr_i && (w_state_nxt == S_MEMWR);
      r_done  <= !pc_clr_i && (w_state_nxt == S_FETCH) && (r_state != S_FETCH);
      if (w_state_nxt == S_FETCH)     r_addr <= w_pc_nxt[ADDR_W-1:0];
      else if (r_state == S_MEMADR)   r_addr <= w_alu_y[ADDR_W-1:0];
      if (r_state == S_MEMADR)        r_wdata <= r_b;
      if (!pc_clr_i) begin
        case (r_state)
          S_FETCH:  if (w_fire) r_ir <= mem_bus.rdata;
          S_DECODE: begin
            r_a       <= r_regs[w_rs];
            r_b       <= r_regs[w_rt];
            r_alu_out <= w_alu_y;
          end
          S_MEMADR, S_EXEC, S_ADDIEX: r_alu_out <= w_alu_y;
          S_MEMRD:  if (w_fire) r_mdr <= mem_bus.rdata;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_rf_we && w_rf_waddr != 5'd0) begin
      r_regs[w_rf_waddr] <= w_rf_wdata;
    end
  end

  assign mem_bus.req     = r_req;
  assign mem_bus.we      = r_we;
  assign mem_bus.addr    = r_addr;
  assign mem_bus.wdata   = r_wdata;
  assign pc_o            = r_pc;
  assign state_o         = r_state;
  assign instr_done_o    = r_done;
  assign halted_o        = (r_state == S_HALT);
  assign ra_debug_data_o = (ra_debug_i == 5'd0) ? 32'd0 : r_regs[ra_debug_i];

endmodule
